flexi_core: RTL and testbench
=============================

// Module: flexi_core
// PURPOSE
// - 4-bit single-cycle accumulator microcontroller core. Fetches 8-bit instructions from an external ROM addressed by PC.
// - Exchanges data with the environment through a 4-bit input port and a registered 4-bit output port.
// - Runs small reactive programs such as decision-tree classifiers; external logic may page ROMs and force branches.
// PARAMETERS
// - DATA_LEN   4  datapath, accumulator, register and port width
// - PC_LEN     7  program counter width (128-word ROM)
// - INSTR_LEN  8  instruction width
// - Only the default values are supported; the ISA encoding depends on them.
// PORTS
// - CLK    in   1  clock; all state updates on the rising edge
// - RSTN   in   1  asynchronous active-low reset
// - INSTR  in   8  instruction word at ROM[PC]; combinational from the environment
// - IPORT  in   4  input port, sampled by IN
// - PC     out  7  current program counter (ROM address)
// - OPORT  out  4  output port register
// BEHAVIOUR
// Reset and state
// - RSTN low forces PC=0, ACC=0, C=0, R0..R7=0, OPORT=0 immediately, independent of CLK.
// - Reset asserted mid-program aborts the program; execution restarts at PC=0 on the first edge after release.
// - State: ACC[3:0]; carry flag C; register file R[0..7] (4 bits each); PC; OPORT.
// - Z = (ACC==0) and N = ACC[3] are combinational, not stored.
// Timing
// - One instruction per cycle: INSTR at the current PC executes on each rising edge.
// - Results (ACC, R, OPORT, PC) are visible after that edge. No stalls, no pipeline.
// - Default next PC is PC+1, modulo 128 (127 -> 0).
// Encoding and instructions (a = INSTR[2:0], imm = INSTR[3:0])
// - 1ttttttt  JMP t: PC<=t, unconditional. 0x80 = JMP 0, used externally to force a restart.
// - 00000aaa  LD:   ACC<=R[a]
// - 00001aaa  ST:   R[a]<=ACC
// - 00010aaa  ADD:  {C,ACC}<=ACC+R[a]
// - 00011aaa  SUB:  ACC<=ACC-R[a]; C<=(ACC>=R[a]) unsigned (no-borrow)
// - 00100aaa  NAND: ACC<=~(ACC&R[a])
// - 00101aaa  XOR:  ACC<=ACC^R[a]
// - 00110xxx  IN:   ACC<=IPORT
// - 00111xxx  OUT:  OPORT<=ACC; OPORT holds until the next OUT or reset
// - 0100iiii  LDI:  ACC<=imm
// - 0101iiii  ADDI: {C,ACC}<=ACC+imm
// - 0110vxcc  SKIP: cond = cc 00:Z, 01:N, 10:C, 11:1, inverted when v=1.
//   cond true -> PC<=PC+2 (mod 128), else PC+1.
// - 0111iiii  ANDI: ACC<=ACC&imm
// Flag and arithmetic rules
// - C changes only on ADD, SUB, ADDI; all other instructions keep C.
// - Arithmetic wraps modulo 16.
// - ST to R[a] and LD of R[a] in the next cycle returns the stored value.
// - IN samples IPORT at the executing edge; IPORT needs no other timing.
// TESTING
// - Reset: hold RSTN=0 mid-run -> PC=0, OPORT=0 asynchronously. Release -> PC=1 after one edge executing ROM[0].
// - LDI 5; OUT -> OPORT=5 after the 2nd edge. ADDI 0xC; OUT -> OPORT=1, C=1.
// - IPORT=9: IN; ST R3; LDI 9; SUB R3; SKIP Z -> PC advances by 2; C=1.
// - PC=5, INSTR=0x80 held -> PC=0 next edge and stays 0. PC=127 with a non-jump instruction -> PC=0.
// - LDI 3; SUB R0 (R0=0) then LDI 2; SUB of R holding 7 -> ACC=0xB, C=0, N=1; SKIP N skips, SKIP !N does not.
// - Decision-tree program: OUT sequence of lower-2-bit codes 1,0,1 on OPORT appears in order, one OUT per cycle.

Source files
------------

// File: rtl/flexi_core.sv
// flexi_core: 4-bit single-cycle accumulator core with an 8-entry register file.
// The instruction at ROM[PC] executes on every rising edge; there is no pipeline and no stall.
module flexi_core #(
    parameter int unsigned DATA_LEN  = 4,
    parameter int unsigned PC_LEN    = 7,
    parameter int unsigned INSTR_LEN = 8
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic [INSTR_LEN-1:0] INSTR,
    input  logic [DATA_LEN-1:0]  IPORT,
    output logic [PC_LEN-1:0]    PC,
    output logic [DATA_LEN-1:0]  OPORT
);

    localparam int unsigned NumRegs = 8;

    typedef enum logic [3:0] {
        OpJmp,
        OpLd,
        OpSt,
        OpAdd,
        OpSub,
        OpNand,
        OpXor,
        OpIn,
        OpOut,
        OpLdi,
        OpAddi,
        OpSkip,
        OpAndi
    } op_e;

    // Architectural state
    logic [PC_LEN-1:0]   pc_q, pc_d;
    logic [DATA_LEN-1:0] acc_q, acc_d;
    logic                c_q, c_d;
    logic [DATA_LEN-1:0] oport_q, oport_d;
    logic [DATA_LEN-1:0] rf_q [NumRegs];
    logic                rf_we;

    // Decoded instruction fields
    op_e                 op;
    logic [2:0]          reg_addr;
    logic [DATA_LEN-1:0] imm;
    logic [PC_LEN-1:0]   jmp_target;
    logic                skip_inv;
    logic [1:0]          skip_cc;

    // Datapath
    logic [DATA_LEN-1:0] r_val;
    logic [DATA_LEN-1:0] addend;
    logic [DATA_LEN:0]   sum;
    logic [DATA_LEN-1:0] diff;
    logic                no_borrow;
    logic                flag_z;
    logic                flag_n;
    logic                skip_cond;
    logic                skip_taken;
    logic [PC_LEN-1:0]   pc_inc;
    logic [PC_LEN-1:0]   pc_skip;

    assign reg_addr   = INSTR[2:0];
    assign imm        = INSTR[3:0];
    assign jmp_target = INSTR[6:0];
    assign skip_inv   = INSTR[3];
    assign skip_cc    = INSTR[1:0];

    always_comb begin
        op = OpLd;
        if (INSTR[7]) begin
            op = OpJmp;
        end else begin
            unique case (INSTR[6:4])
                3'b000:  op = INSTR[3] ? OpSt  : OpLd;
                3'b001:  op = INSTR[3] ? OpSub : OpAdd;
                3'b010:  op = INSTR[3] ? OpXor : OpNand;
                3'b011:  op = INSTR[3] ? OpOut : OpIn;
                3'b100:  op = OpLdi;
                3'b101:  op = OpAddi;
                3'b110:  op = OpSkip;
                default: op = OpAndi;
            endcase
        end
    end

    assign r_val     = rf_q[reg_addr];
    assign addend    = (op == OpAddi) ? imm : r_val;
    assign sum       = {1'b0, acc_q} + {1'b0, addend};
    assign diff      = acc_q - r_val;
    assign no_borrow = (acc_q >= r_val);

    // Z and N are derived from the accumulator, never stored
    assign flag_z = (acc_q == '0);
    assign flag_n = acc_q[DATA_LEN-1];

    always_comb begin
        skip_cond = 1'b1;
        unique case (skip_cc)
            2'b00:   skip_cond = flag_z;
            2'b01:   skip_cond = flag_n;
            2'b10:   skip_cond = c_q;
            default: skip_cond = 1'b1;
        endcase
    end

    assign skip_taken = skip_cond ^ skip_inv;
    assign pc_inc     = pc_q + PC_LEN'(1);
    assign pc_skip    = pc_q + PC_LEN'(2);

    always_comb begin
        pc_d    = pc_inc;
        acc_d   = acc_q;
        c_d     = c_q;
        oport_d = oport_q;
        rf_we   = 1'b0;
        unique case (op)
            OpJmp:  pc_d = jmp_target;
            OpLd:   acc_d = r_val;
            OpSt:   rf_we = 1'b1;
            OpAdd:  {c_d, acc_d} = sum;
            OpSub: begin
                acc_d = diff;
                c_d   = no_borrow;
            end
            OpNand: acc_d = ~(acc_q & r_val);
            OpXor:  acc_d = acc_q ^ r_val;
            OpIn:   acc_d = IPORT;
            OpOut:  oport_d = acc_q;
            OpLdi:  acc_d = imm;
            OpAddi: {c_d, acc_d} = sum;
            OpSkip: pc_d = skip_taken ? pc_skip : pc_inc;
            OpAndi: acc_d = acc_q & imm;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pc_q    <= '0;
            acc_q   <= '0;
            c_q     <= 1'b0;
            oport_q <= '0;
            for (int i = 0; i < NumRegs; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            oport_q <= oport_d;
            if (rf_we) begin
                rf_q[reg_addr] <= acc_q;
            end
        end
    end

    assign PC    = pc_q;
    assign OPORT = oport_q;

endmodule

// File: tb/tb_flexi_core.sv
// Directed testbench for flexi_core: a behavioural ROM feeds INSTR from PC, and
// hand-computed PC/OPORT values are checked after selected edges.
module tb_flexi_core;

    logic       clk;
    logic       rstn;
    logic [7:0] instr;
    logic [3:0] iport;
    logic [6:0] pc;
    logic [3:0] oport;

    logic [7:0] rom [128];
    logic       force_en;
    logic [7:0] force_val;

    int checks;
    int errors;

    assign instr = force_en ? force_val : rom[pc];

    flexi_core dut (
        .CLK  (clk),
        .RSTN (rstn),
        .INSTR(instr),
        .IPORT(iport),
        .PC   (pc),
        .OPORT(oport)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_on();
        @(negedge clk);
        rstn = 1'b0;
        #1;
    endtask

    task automatic reset_off();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic clear_rom();
        foreach (rom[i]) rom[i] = 8'h00;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rstn      = 1'b0;
        iport     = 4'h0;
        force_en  = 1'b0;
        force_val = 8'h00;
        clear_rom();

        @(negedge clk);
        check("reset_pc", 32'(pc), 0);
        check("reset_oport", 32'(oport), 0);

        // LDI 5; OUT; ADDI C; OUT; SKIP C; LDI F; OUT; JMP 7
        rom[0] = 8'h45; rom[1] = 8'h38; rom[2] = 8'h5C; rom[3] = 8'h38;
        rom[4] = 8'h62; rom[5] = 8'h4F; rom[6] = 8'h38; rom[7] = 8'h87;
        reset_off();
        step(1); check("first_fetch_pc", 32'(pc), 1);
        step(1); check("ldi_out", 32'(oport), 5);
        step(2); check("addi_wrap_out", 32'(oport), 1);
        step(1); check("skip_c_pc", 32'(pc), 6);
        step(2); check("skip_c_oport", 32'(oport), 1);
        check("jmp_self_pc", 32'(pc), 7);

        // Asynchronous reset mid-program, then restart from 0
        reset_on();
        check("async_rst_pc", 32'(pc), 0);
        check("async_rst_oport", 32'(oport), 0);
        step(1); check("rst_held_pc", 32'(pc), 0);
        reset_off();
        step(1); check("restart_pc", 32'(pc), 1);
        step(1); check("restart_out", 32'(oport), 5);

        // IN; ST R3; LDI 9; SUB R3; SKIP Z; OUT; SKIP C; OUT; ADDI A; OUT; ADDI F; JMP 11
        reset_on();
        clear_rom();
        rom[0] = 8'h30; rom[1] = 8'h0B; rom[2]  = 8'h49; rom[3]  = 8'h1B;
        rom[4] = 8'h60; rom[5] = 8'h38; rom[6]  = 8'h62; rom[7]  = 8'h38;
        rom[8] = 8'h5A; rom[9] = 8'h38; rom[10] = 8'h5F; rom[11] = 8'h8B;
        iport = 4'h9;
        reset_off();
        step(5); check("skip_z_pc", 32'(pc), 6);
        step(1); check("sub_nb_skip_c_pc", 32'(pc), 8);
        step(2); check("sub_zero_out", 32'(oport), 4'hA);
        step(2); check("jmp11_pc", 32'(pc), 11);

        // Reset must clear R3 (=9) and C (=1) left by the previous program
        // LDI F; OUT; LD R3; OUT; SKIP C; JMP 5
        reset_on();
        clear_rom();
        rom[0] = 8'h4F; rom[1] = 8'h38; rom[2] = 8'h03; rom[3] = 8'h38;
        rom[4] = 8'h62; rom[5] = 8'h85;
        reset_off();
        step(2); check("ldi_f_out", 32'(oport), 4'hF);
        step(2); check("rst_clears_reg", 32'(oport), 0);
        step(1); check("rst_clears_c", 32'(pc), 5);

        // LDI 3; SUB R0; LDI 7; ST R5; LDI 2; SUB R5; OUT; SKIP N; LDI F;
        // SKIP !N; SKIP !C; LDI F; OUT; JMP 13
        reset_on();
        clear_rom();
        rom[0] = 8'h43; rom[1] = 8'h18; rom[2]  = 8'h47; rom[3]  = 8'h0D;
        rom[4] = 8'h42; rom[5] = 8'h1D; rom[6]  = 8'h38; rom[7]  = 8'h61;
        rom[8] = 8'h4F; rom[9] = 8'h69; rom[10] = 8'h6A; rom[11] = 8'h4F;
        rom[12] = 8'h38; rom[13] = 8'h8D;
        reset_off();
        step(7); check("sub_borrow_out", 32'(oport), 4'hB);
        step(1); check("skip_n_pc", 32'(pc), 9);
        step(1); check("skip_not_n_pc", 32'(pc), 10);
        step(1); check("skip_not_c_pc", 32'(pc), 12);
        step(1); check("borrow_acc_kept", 32'(oport), 4'hB);

        // Register file, logic ops and unconditional skip
        reset_on();
        clear_rom();
        rom[0]  = 8'h4C; rom[1]  = 8'h09; rom[2]  = 8'h4A; rom[3]  = 8'h0A;
        rom[4]  = 8'h01; rom[5]  = 8'h38; rom[6]  = 8'h02; rom[7]  = 8'h21;
        rom[8]  = 8'h38; rom[9]  = 8'h29; rom[10] = 8'h38; rom[11] = 8'h01;
        rom[12] = 8'h76; rom[13] = 8'h38; rom[14] = 8'h63; rom[15] = 8'h4F;
        rom[16] = 8'h80;
        reset_off();
        step(6); check("st_ld_out", 32'(oport), 4'hC);
        step(3); check("nand_out", 32'(oport), 4'h7);
        step(2); check("xor_out", 32'(oport), 4'hB);
        step(3); check("andi_out", 32'(oport), 4'h4);
        step(1); check("skip_always_pc", 32'(pc), 16);
        step(1); check("jmp0_pc", 32'(pc), 0);

        // Externally forced JMP 0
        reset_on();
        clear_rom();
        reset_off();
        step(5); check("nop_run_pc", 32'(pc), 5);
        force_val = 8'h80;
        force_en  = 1'b1;
        step(1); check("force_jmp_pc", 32'(pc), 0);
        step(1); check("force_hold_pc", 32'(pc), 0);
        force_en  = 1'b0;

        // PC wrap from 127 and skip wrap from 126
        reset_on();
        rom[0] = 8'hFF;
        reset_off();
        step(1); check("jmp127_pc", 32'(pc), 127);
        step(1); check("pc_wrap", 32'(pc), 0);
        reset_on();
        rom[0] = 8'hFE; rom[126] = 8'h63;
        reset_off();
        step(1); check("jmp126_pc", 32'(pc), 126);
        step(1); check("skip_wrap", 32'(pc), 0);
        rom[126] = 8'h00;

        // Decision tree: class 1 when IPORT >= 8, else class 0
        // IN; SKIP !N; JMP 5; LDI 0; JMP 6; LDI 1; OUT; JMP 0
        reset_on();
        clear_rom();
        rom[0] = 8'h30; rom[1] = 8'h69; rom[2] = 8'h85; rom[3] = 8'h40;
        rom[4] = 8'h86; rom[5] = 8'h41; rom[6] = 8'h38; rom[7] = 8'h80;
        iport = 4'hA;
        reset_off();
        step(5); check("dt_first_out", 32'(oport), 1);
        check("dt_first_pc", 32'(pc), 7);
        step(1);
        iport = 4'h3;
        step(4); check("dt_hold", 32'(oport), 1);
        step(1); check("dt_second_out", 32'(oport), 0);
        step(1);
        iport = 4'hC;
        step(5); check("dt_third_out", 32'(oport), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
